// File: rtl/riscv_core_mc.sv
// Multi-cycle RV32I core with req/ack instruction and data bus ports.
// Ports: clk, rst (async, active-high); imem_req/addr/ack/rdata fetch bus;
// dmem_req/we/addr/be/wdata/ack/rdata data bus; instruction (IR);
// halted (ECALL/EBREAK), fault (illegal, misaligned, timeout); retired count.
module riscv_core_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] instruction,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);
    localparam int unsigned WCW = 8;
    localparam logic [2:0] S_START = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                           S_WB = 3'd4, S_HALT = 3'd5, S_FAULT = 3'd6;
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67,
                           OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23,
                           OP_IMM = 7'h13, OP_REG = 7'h33, OP_FENCE = 7'h0F, OP_SYSTEM = 7'h73;

    logic [2:0]     state, state_n;
    logic [31:0]    pc, pc_n, ir, ir_n, retired_n, rd_val, rd_val_n, next_pc, next_pc_n;
    logic [WCW-1:0] wait_cnt, wait_n;
    logic           wb_en, wb_en_n, imem_req_n, dmem_req_n, dmem_we_n;
    logic [31:0]    imem_addr_n, dmem_addr_n, dmem_wdata_n;
    logic [3:0]     dmem_be_n;
    logic [31:0]    regs [32];

    // Instruction fields and immediates
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_v, rs2_v, op_b, pc_plus4;
    assign opcode   = ir[6:0];
    assign rd       = ir[11:7];
    assign f3       = ir[14:12];
    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign imm_i    = {{20{ir[31]}}, ir[31:20]};
    assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u    = {ir[31:12], 12'h000};
    assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign rs1_v    = regs[rs1];
    assign rs2_v    = regs[rs2];
    assign op_b     = (opcode == OP_REG) ? rs2_v : imm_i;
    assign pc_plus4 = pc + 32'd4;

    // ALU; ir[30] selects SUB/SRA (for immediates only SRAI uses it)
    logic [31:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (f3)
            3'd0: alu_res = (opcode == OP_REG && ir[30]) ? rs1_v - op_b : rs1_v + op_b;
            3'd1: alu_res = rs1_v << op_b[4:0];
            3'd2: alu_res = {31'd0, $signed(rs1_v) < $signed(op_b)};
            3'd3: alu_res = {31'd0, rs1_v < op_b};
            3'd4: alu_res = rs1_v ^ op_b;
            3'd5: alu_res = ir[30] ? 32'($signed(rs1_v) >>> op_b[4:0]) : rs1_v >> op_b[4:0];
            3'd6: alu_res = rs1_v | op_b;
            default: alu_res = rs1_v & op_b;
        endcase
    end

    // Branch condition
    logic taken;
    always_comb begin
        taken = 1'b0;
        case (f3)
            3'd0: taken = (rs1_v == rs2_v);
            3'd1: taken = (rs1_v != rs2_v);
            3'd4: taken = ($signed(rs1_v) < $signed(rs2_v));
            3'd5: taken = ($signed(rs1_v) >= $signed(rs2_v));
            3'd6: taken = (rs1_v < rs2_v);
            3'd7: taken = (rs1_v >= rs2_v);
            default: taken = 1'b0;
        endcase
    end

    // Decode: writeback value, next PC and instruction class
    logic        illegal, is_sys, is_ls, writes_rd;
    logic [31:0] wb_data, target;
    always_comb begin
        illegal = 1'b0; is_sys = 1'b0; is_ls = 1'b0; writes_rd = 1'b1;
        wb_data = alu_res; target = pc_plus4;
        case (opcode)
            OP_LUI:    wb_data = imm_u;
            OP_AUIPC:  wb_data = pc + imm_u;
            OP_JAL:    begin wb_data = pc_plus4; target = pc + imm_j; end
            OP_JALR:   begin wb_data = pc_plus4; target = (rs1_v + imm_i) & ~32'd1; end
            OP_BRANCH: begin writes_rd = 1'b0; if (taken) target = pc + imm_b; end
            OP_LOAD:   is_ls = 1'b1;
            OP_STORE:  begin is_ls = 1'b1; writes_rd = 1'b0; end
            OP_IMM, OP_REG: ;
            OP_FENCE:  writes_rd = 1'b0;
            OP_SYSTEM: begin is_sys = 1'b1; writes_rd = 1'b0; end
            default:   begin illegal = 1'b1; writes_rd = 1'b0; end
        endcase
    end

    // Memory address, lanes and alignment; f3[1:0]==3 has no legal size
    logic [31:0] ls_addr, st_data;
    logic [3:0]  ls_be;
    logic        mis;
    assign ls_addr = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
    always_comb begin
        ls_be = 4'b1111; st_data = rs2_v; mis = 1'b0;
        case (f3[1:0])
            2'd0: begin ls_be = 4'b0001 << ls_addr[1:0]; st_data = {4{rs2_v[7:0]}}; end
            2'd1: begin ls_be = 4'b0011 << ls_addr[1:0]; st_data = {2{rs2_v[15:0]}};
                        mis = ls_addr[0]; end
            2'd2: mis = (ls_addr[1:0] != 2'd0);
            default: mis = 1'b1;
        endcase
    end

    // Load data: move the addressed lane down, then extend
    logic [31:0] ld_shift, ld_data;
    assign ld_shift = dmem_rdata >> {dmem_addr[1:0], 3'b000};
    always_comb begin
        case (f3)
            3'd0: ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1: ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd4: ld_data = {24'd0, ld_shift[7:0]};
            3'd5: ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state; pc_n = pc; ir_n = ir; retired_n = retired; wait_n = wait_cnt;
        imem_req_n = imem_req; imem_addr_n = imem_addr;
        dmem_req_n = dmem_req; dmem_we_n = dmem_we; dmem_addr_n = dmem_addr;
        dmem_be_n = dmem_be; dmem_wdata_n = dmem_wdata;
        rd_val_n = rd_val; next_pc_n = next_pc; wb_en_n = wb_en;
        case (state)
            S_START: begin
                state_n = S_FETCH; imem_req_n = 1'b1; imem_addr_n = pc; wait_n = '0;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_n = imem_rdata; imem_req_n = 1'b0; state_n = S_EXEC;
                end else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
                    imem_req_n = 1'b0; state_n = S_FAULT;
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end
            S_EXEC: begin
                rd_val_n = wb_data; next_pc_n = target; wb_en_n = writes_rd;
                if (illegal)     state_n = S_FAULT;
                else if (is_sys) state_n = S_HALT;
                else if (is_ls) begin
                    if (mis) state_n = S_FAULT;
                    else begin
                        state_n = S_MEM; wait_n = '0; dmem_req_n = 1'b1;
                        dmem_we_n = (opcode == OP_STORE); dmem_addr_n = ls_addr;
                        dmem_be_n = ls_be; dmem_wdata_n = st_data;
                    end
                end
                else if (target[1]) state_n = S_FAULT;
                else                state_n = S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    dmem_req_n = 1'b0; state_n = S_WB;
                    if (opcode == OP_LOAD) rd_val_n = ld_data;
                end else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
                    dmem_req_n = 1'b0; state_n = S_FAULT;
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end
            S_WB: begin
                pc_n = next_pc; retired_n = retired + 32'd1; state_n = S_FETCH;
                imem_req_n = 1'b1; imem_addr_n = next_pc; wait_n = '0;
            end
            default: state_n = state;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_START; pc <= RESET_PC; ir <= '0; retired <= '0; wait_cnt <= '0;
            imem_req <= 1'b0; imem_addr <= '0; dmem_req <= 1'b0; dmem_we <= 1'b0;
            dmem_addr <= '0; dmem_be <= '0; dmem_wdata <= '0;
            halted <= 1'b0; fault <= 1'b0; rd_val <= '0; next_pc <= '0; wb_en <= 1'b0;
        end else begin
            state <= state_n; pc <= pc_n; ir <= ir_n; retired <= retired_n; wait_cnt <= wait_n;
            imem_req <= imem_req_n; imem_addr <= imem_addr_n; dmem_req <= dmem_req_n;
            dmem_we <= dmem_we_n; dmem_addr <= dmem_addr_n; dmem_be <= dmem_be_n;
            dmem_wdata <= dmem_wdata_n;
            halted <= (state_n == S_HALT); fault <= (state_n == S_FAULT);
            rd_val <= rd_val_n; next_pc <= next_pc_n; wb_en <= wb_en_n;
        end
    end

    // Register file; x0 is never written so it reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (state == S_WB && wb_en && rd != 5'd0) begin
            regs[rd] <= rd_val;
        end
    end

    assign instruction = ir;
endmodule
